risc_controller: RTL and testbench

Eight-phase instruction sequencer for the 8-bit RISC CPU; the control-side counterpart of the ALU. It steps a 3-bit phase counter through fetch and execute, and drives the per-phase control strobes from the instruction register opcode. Those strobes are: address mux select, memory read/write, IR/PC/AC loads and data-bus enable. For SKZ it consumes the ALU `is_zero` flag. It sits between the instruction register, the ALU and the memory/PC datapath.

---
 rtl/risc_controller.sv | 165 ++++++++++++++++
 tb/tb_risc_controller.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/risc_controller.sv
// risc_controller
// Eight-phase instruction sequencer for the 8-bit RISC CPU. A 3-bit phase
// counter steps through fetch (phases 0-3) and execute (phases 4-7). The
// control strobes are a combinational decode of the phase, the IR opcode
// and the ALU zero flag. HLT freezes the sequencer at phase 4 until reset.
//
// Ports:
//   clk     in   system clock, rising-edge active
//   rst     in   synchronous active-high reset
//   opcode  in   IR opcode field (HLT SKZ ADD AND XOR LDA STO JMP)
//   zero    in   ALU is_zero flag, consulted only by SKZ in phase 6
//   sel     out  address mux select (1 = PC, 0 = IR operand address)
//   rd      out  memory read strobe
//   ld_ir   out  load instruction register
//   inc_pc  out  increment PC
//   ld_pc   out  load PC from IR operand address
//   ld_ac   out  load accumulator from ALU output
//   wr      out  memory write strobe
//   data_e  out  drive accumulator onto data bus
//   halt    out  CPU halted
//   phase   out  current phase (debug)

module risc_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       ld_ac,
    output logic       wr,
    output logic       data_e,
    output logic       halt,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_e;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    phase_e phase_r;
    phase_e phase_next_s;
    logic   halted_r;
    logic   halted_next_s;
    logic   is_aluop_s;
    logic   is_skz_s;
    logic   is_sto_s;
    logic   is_jmp_s;
    logic   is_hlt_s;

    // Phase and sticky-halt state register; reset wins over freeze and advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r  <= PH_INST_ADDR;
            halted_r <= 1'b0;
        end else begin
            phase_r  <= phase_next_s;
            halted_r <= halted_next_s;
        end
    end

    // Next-state sequencing and per-phase strobe decode.
    always_comb begin
        phase_next_s  = phase_r;
        halted_next_s = halted_r;
        sel           = 1'b0;
        rd            = 1'b0;
        ld_ir         = 1'b0;
        inc_pc        = 1'b0;
        ld_pc         = 1'b0;
        ld_ac         = 1'b0;
        wr            = 1'b0;
        data_e        = 1'b0;
        halt          = 1'b0;
        phase         = 3'd0;

        is_aluop_s = (opcode == OP_ADD) || (opcode == OP_AND) ||
                     (opcode == OP_XOR) || (opcode == OP_LDA);
        is_skz_s   = (opcode == OP_SKZ);
        is_sto_s   = (opcode == OP_STO);
        is_jmp_s   = (opcode == OP_JMP);
        is_hlt_s   = (opcode == OP_HLT);

        // Sequencing: once halted, hold phase 4; HLT is caught in phase 4
        // so the single inc_pc of that cycle still happens.
        if (halted_r) begin
            phase_next_s  = PH_OP_ADDR;
            halted_next_s = 1'b1;
        end else if ((phase_r == PH_OP_ADDR) && is_hlt_s) begin
            phase_next_s  = PH_OP_ADDR;
            halted_next_s = 1'b1;
        end else begin
            phase_next_s  = phase_e'(phase_r + 3'd1);
            halted_next_s = 1'b0;
        end

        // Strobes: reset blanks everything, halted exposes only halt.
        if (rst) begin
            phase = 3'd0;
        end else if (halted_r) begin
            phase = phase_r;
            halt  = 1'b1;
        end else begin
            phase = phase_r;
            case (phase_r)
                PH_INST_ADDR: begin
                    sel = 1'b1;
                end
                PH_INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = is_hlt_s;
                end
                PH_OP_FETCH: begin
                    rd = is_aluop_s;
                end
                PH_ALU_OP: begin
                    rd     = is_aluop_s;
                    inc_pc = is_skz_s & zero;
                    ld_pc  = is_jmp_s;
                    data_e = is_sto_s;
                end
                PH_STORE: begin
                    rd     = is_aluop_s;
                    ld_ac  = is_aluop_s;
                    inc_pc = is_jmp_s;
                    ld_pc  = is_jmp_s;
                    wr     = is_sto_s;
                    data_e = is_sto_s;
                end
                default: begin
                    sel = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_risc_controller.sv
// Table-driven bench for risc_controller. Each record is one clock cycle:
// inputs applied just after the rising edge, outputs compared on the
// falling edge. Strobe vector bit order:
//   {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}

module tb_risc_controller;

    localparam logic [2:0] HLT = 3'b000;
    localparam logic [2:0] SKZ = 3'b001;
    localparam logic [2:0] ADD = 3'b010;
    localparam logic [2:0] AND = 3'b011;
    localparam logic [2:0] XOR = 3'b100;
    localparam logic [2:0] LDA = 3'b101;
    localparam logic [2:0] STO = 3'b110;
    localparam logic [2:0] JMP = 3'b111;

    typedef struct {
        logic       rst;
        logic [2:0] op;
        logic       z;
        logic [2:0] ph;
        logic [8:0] out;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] opcode;
    logic       zero;
    logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
    logic [2:0] phase;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    risc_controller dut (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .zero   (zero),
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .inc_pc (inc_pc),
        .ld_pc  (ld_pc),
        .ld_ac  (ld_ac),
        .wr     (wr),
        .data_e (data_e),
        .halt   (halt),
        .phase  (phase)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [2:0] op, input logic z,
                       input logic [2:0] ph, input logic [8:0] out);
        vec_t v;
        v.rst = r; v.op = op; v.z = z; v.ph = ph; v.out = out;
        vecs.push_back(v);
    endtask

    // Fetch phases 0-3 are opcode-independent.
    task automatic add_fetch(input logic [2:0] op);
        add(1'b0, op, 1'b0, 3'd0, 9'h100);
        add(1'b0, op, 1'b0, 3'd1, 9'h180);
        add(1'b0, op, 1'b0, 3'd2, 9'h1C0);
        add(1'b0, op, 1'b0, 3'd3, 9'h1C0);
    endtask

    task automatic apply(input logic r, input logic [2:0] op, input logic z);
        rst    = r;
        opcode = op;
        zero   = z;
    endtask

    task automatic check(input string name, input logic [2:0] exp_ph,
                         input logic [8:0] exp_out);
        logic [8:0] got;
        @(negedge clk);
        got = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};
        n_vec++;
        if (got !== exp_out || phase !== exp_ph) begin
            n_bad++;
            $display("FAIL %s: got phase=%0d strobes=%b, expected phase=%0d strobes=%b",
                     name, phase, got, exp_ph, exp_out);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        apply(1'b1, ADD, 1'b0);

        // Reset for two cycles
        add(1'b1, ADD, 1'b0, 3'd0, 9'h000);
        add(1'b1, ADD, 1'b0, 3'd0, 9'h000);
        // ADD; fetch opcodes are junk and must be ignored
        add(1'b0, HLT, 1'b0, 3'd0, 9'h100);
        add(1'b0, JMP, 1'b1, 3'd1, 9'h180);
        add(1'b0, STO, 1'b0, 3'd2, 9'h1C0);
        add(1'b0, HLT, 1'b1, 3'd3, 9'h1C0);
        add(1'b0, ADD, 1'b1, 3'd4, 9'h020);
        add(1'b0, ADD, 1'b1, 3'd5, 9'h080);
        add(1'b0, ADD, 1'b1, 3'd6, 9'h080);
        add(1'b0, ADD, 1'b1, 3'd7, 9'h088);
        // STO
        add_fetch(STO);
        add(1'b0, STO, 1'b0, 3'd4, 9'h020);
        add(1'b0, STO, 1'b0, 3'd5, 9'h000);
        add(1'b0, STO, 1'b0, 3'd6, 9'h002);
        add(1'b0, STO, 1'b0, 3'd7, 9'h006);
        // SKZ with zero=1 (skip)
        add_fetch(SKZ);
        add(1'b0, SKZ, 1'b1, 3'd4, 9'h020);
        add(1'b0, SKZ, 1'b1, 3'd5, 9'h000);
        add(1'b0, SKZ, 1'b1, 3'd6, 9'h020);
        add(1'b0, SKZ, 1'b1, 3'd7, 9'h000);
        // SKZ with zero=0 (no skip)
        add_fetch(SKZ);
        add(1'b0, SKZ, 1'b0, 3'd4, 9'h020);
        add(1'b0, SKZ, 1'b0, 3'd5, 9'h000);
        add(1'b0, SKZ, 1'b0, 3'd6, 9'h000);
        add(1'b0, SKZ, 1'b0, 3'd7, 9'h000);
        // JMP
        add_fetch(JMP);
        add(1'b0, JMP, 1'b1, 3'd4, 9'h020);
        add(1'b0, JMP, 1'b1, 3'd5, 9'h000);
        add(1'b0, JMP, 1'b1, 3'd6, 9'h010);
        add(1'b0, JMP, 1'b1, 3'd7, 9'h030);
        // AND, then XOR: zero must not matter outside SKZ
        add_fetch(AND);
        add(1'b0, AND, 1'b1, 3'd4, 9'h020);
        add(1'b0, AND, 1'b1, 3'd5, 9'h080);
        add(1'b0, AND, 1'b1, 3'd6, 9'h080);
        add(1'b0, AND, 1'b1, 3'd7, 9'h088);
        add_fetch(XOR);
        add(1'b0, XOR, 1'b1, 3'd4, 9'h020);
        add(1'b0, XOR, 1'b1, 3'd5, 9'h080);
        add(1'b0, XOR, 1'b1, 3'd6, 9'h080);
        add(1'b0, XOR, 1'b0, 3'd7, 9'h088);
        // LDA aborted by reset during phase 6
        add_fetch(LDA);
        add(1'b0, LDA, 1'b0, 3'd4, 9'h020);
        add(1'b0, LDA, 1'b0, 3'd5, 9'h080);
        add(1'b1, LDA, 1'b0, 3'd0, 9'h000);
        add(1'b0, LDA, 1'b0, 3'd0, 9'h100);
        add(1'b0, LDA, 1'b0, 3'd1, 9'h180);
        // Fetch of a HLT instruction
        add(1'b0, HLT, 1'b0, 3'd2, 9'h1C0);
        add(1'b0, HLT, 1'b0, 3'd3, 9'h1C0);

        // Sync to just after a rising edge, then run the table
        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].op, vecs[i].z);
            check($sformatf("vec%0d", i), vecs[i].ph, vecs[i].out);
        end

        // HLT detected at phase 4: halt plus a single inc_pc
        apply(1'b0, HLT, 1'b0);
        check("hlt_detect", 3'd4, 9'h021);
        // Frozen for 20 cycles regardless of opcode/zero
        for (int k = 0; k < 20; k++) begin
            apply(1'b0, (k % 2 == 0) ? JMP : ADD, k[0]);
            check($sformatf("hlt_hold%0d", k), 3'd4, 9'h001);
        end
        // Reset releases the halt
        apply(1'b1, HLT, 1'b0);
        check("hlt_rst", 3'd0, 9'h000);
        apply(1'b0, ADD, 1'b0);
        check("hlt_after_rst0", 3'd0, 9'h100);
        check("hlt_after_rst1", 3'd1, 9'h180);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
